// File: rtl/shift_unit_pkg.sv
// Shared opcodes and FSM state type for the parametrised shift unit.
// Imported by the barrel shifter and the top-level register block.
package shift_unit_pkg;

    localparam logic [2:0] OP_CLR   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SAR   = 3'b100;
    localparam logic [2:0] OP_SERIN = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_ROL   = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/shift_barrel.sv
// Combinational barrel shifter for SHR/SHL/SAR/ROR/ROL.
// hold flags an effective zero shift, where the caller keeps its carry.
module shift_barrel
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         op,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               hold
);

    localparam logic [SHAMT_W:0] WL = (SHAMT_W + 1)'(WIDTH);

    logic               oor;
    logic [SHAMT_W-1:0] rot_amt;
    logic [WIDTH:0]     shr_ext;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     sar_ext;
    logic [2*WIDTH-1:0] ror_ext;
    logic [2*WIDTH-1:0] rol_ext;

    // Extended shifts carry the last bit shifted out in the extra position
    always_comb begin
        oor     = ({1'b0, shamt} >= WL);
        rot_amt = SHAMT_W'({1'b0, shamt} % WL);
        shr_ext = {value, 1'b0} >> shamt;
        shl_ext = {1'b0, value} << shamt;
        sar_ext = $signed({value, 1'b0}) >>> shamt;
        ror_ext = {value, value} >> rot_amt;
        rol_ext = {value, value} << rot_amt;
    end

    // Select result and carry per opcode, saturating out-of-range shifts
    always_comb begin
        result = value;
        carry  = 1'b0;
        hold   = 1'b0;
        case (op)
            OP_SHR: begin
                hold = (shamt == '0);
                if (oor) begin
                    result = '0;
                    carry  = 1'b0;
                end else begin
                    result = shr_ext[WIDTH:1];
                    carry  = shr_ext[0];
                end
            end
            OP_SHL: begin
                hold = (shamt == '0);
                if (oor) begin
                    result = '0;
                    carry  = 1'b0;
                end else begin
                    result = shl_ext[WIDTH-1:0];
                    carry  = shl_ext[WIDTH];
                end
            end
            OP_SAR: begin
                hold = (shamt == '0);
                if (oor) begin
                    result = {WIDTH{value[WIDTH-1]}};
                    carry  = value[WIDTH-1];
                end else begin
                    result = sar_ext[WIDTH:1];
                    carry  = sar_ext[0];
                end
            end
            OP_ROR: begin
                hold   = (rot_amt == '0);
                result = ror_ext[WIDTH-1:0];
                carry  = ror_ext[WIDTH-1];
            end
            OP_ROL: begin
                hold   = (rot_amt == '0);
                result = rol_ext[2*WIDTH-1:WIDTH];
                carry  = rol_ext[WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_unit_param.sv
// WIDTH-bit opcode-driven shift register with carry-out and a
// multi-cycle serial-in collector using a busy/done handshake.
module shift_unit_param
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    input  logic               ser_in,
    output logic [WIDTH-1:0]   data_out,
    output logic               carry,
    output logic               busy,
    output logic               done
);

    localparam logic [SHAMT_W-1:0] LAST = SHAMT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   bar_result;
    logic               bar_carry;
    logic               bar_hold;

    shift_barrel #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_barrel (
        .value (data_q),
        .shamt (shamt),
        .op    (op),
        .result(bar_result),
        .carry (bar_carry),
        .hold  (bar_hold)
    );

    // State register; reset abandons any partial collection
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
        end
    end

    // Next state: ops accepted only in IDLE, collection runs LSB first
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_CLR: begin
                            data_d  = '0;
                            carry_d = 1'b0;
                        end
                        OP_LOAD: begin
                            data_d  = data_in;
                            carry_d = 1'b0;
                        end
                        OP_SERIN: begin
                            shadow_d[0] = ser_in;
                            cnt_d       = SHAMT_W'(1);
                            state_d     = COLLECT;
                        end
                        default: begin
                            data_d = bar_result;
                            if (!bar_hold) begin
                                carry_d = bar_carry;
                            end
                        end
                    endcase
                end
            end
            COLLECT: begin
                if (cnt_q == LAST) begin
                    data_d  = {ser_in, shadow_q[WIDTH-2:0]};
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    shadow_d[cnt_q] = ser_in;
                    cnt_d           = cnt_q + SHAMT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs straight from registered state
    always_comb begin
        busy     = (state_q == COLLECT);
        done     = done_q;
        data_out = data_q;
        carry    = carry_q;
    end

endmodule

// File: tb/tb_shift_unit_param.sv
// Directed plus model-checked bench for shift_unit_param, WIDTH=8 and 16.
// Expected results are queued as stimulus is driven and popped after each edge.
module tb_shift_unit_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [2:0]  sh8 = 3'd0;
    logic [7:0]  din8 = 8'd0;
    logic        ser8 = 1'b0;
    logic [7:0]  dout8;
    logic        carry8, busy8, done8;

    logic        v16 = 1'b0;
    logic [2:0]  op16 = 3'd0;
    logic [3:0]  sh16 = 4'd0;
    logic [15:0] din16 = 16'd0;
    logic        ser16 = 1'b0;
    logic [15:0] dout16;
    logic        carry16, busy16, done16;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          sel;
        logic [15:0] data;
        logic        c;
        logic        b;
        logic        d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_unit_param #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .op_valid(v8), .op(op8), .shamt(sh8),
        .data_in(din8), .ser_in(ser8), .data_out(dout8),
        .carry(carry8), .busy(busy8), .done(done8)
    );

    shift_unit_param #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .op_valid(v16), .op(op16), .shamt(sh16),
        .data_in(din16), .ser_in(ser16), .data_out(dout16),
        .carry(carry16), .busy(busy16), .done(done16)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv8(input logic v, input logic [2:0] o,
                        input logic [2:0] s, input logic [7:0] d,
                        input logic sr);
        v8 = v; op8 = o; sh8 = s; din8 = d; ser8 = sr;
    endtask

    task automatic drv16(input logic v, input logic [2:0] o,
                         input logic [3:0] s, input logic [15:0] d);
        v16 = v; op16 = o; sh16 = s; din16 = d; ser16 = 1'b0;
    endtask

    task automatic tick(input string tag, input bit sel,
                        input logic [15:0] ed, input logic ec,
                        input logic eb, input logic edn);
        exp_t e;
        e.sel = sel; e.data = ed; e.c = ec; e.b = eb; e.d = edn;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            chk({tag, ".data"}, dout16, e.data);
            chk({tag, ".carry"}, {15'd0, carry16}, {15'd0, e.c});
            chk({tag, ".busy"}, {15'd0, busy16}, {15'd0, e.b});
            chk({tag, ".done"}, {15'd0, done16}, {15'd0, e.d});
        end else begin
            chk({tag, ".data"}, {8'd0, dout8}, e.data);
            chk({tag, ".carry"}, {15'd0, carry8}, {15'd0, e.c});
            chk({tag, ".busy"}, {15'd0, busy8}, {15'd0, e.b});
            chk({tag, ".done"}, {15'd0, done8}, {15'd0, e.d});
        end
    endtask

    // One-bit-at-a-time reference for the 8-bit register ops
    function automatic logic [8:0] mdl(input logic [2:0] o,
                                       input logic [2:0] s,
                                       input logic [7:0] din,
                                       input logic [7:0] d0,
                                       input logic c0);
        logic [7:0] d;
        logic       c;
        d = d0;
        c = c0;
        case (o)
            3'b000: begin d = 8'd0; c = 1'b0; end
            3'b001: begin d = din;  c = 1'b0; end
            default: begin
                for (int k = 0; k < int'(s); k++) begin
                    case (o)
                        3'b010: begin c = d[0]; d = {1'b0, d[7:1]}; end
                        3'b011: begin c = d[7]; d = {d[6:0], 1'b0}; end
                        3'b100: begin c = d[0]; d = {d[7], d[7:1]}; end
                        3'b110: begin c = d[0]; d = {d[0], d[7:1]}; end
                        default: begin c = d[7]; d = {d[6:0], d[7]}; end
                    endcase
                end
            end
        endcase
        return {c, d};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  bits;
        logic [7:0]  md;
        logic        mc;
        logic [2:0]  o;
        logic [2:0]  s;
        logic [7:0]  d;

        bits = 8'b0100_1101;

        rst = 1'b1;
        drv8(1'b1, 3'b001, 3'd0, 8'hEE, 1'b0);
        drv16(1'b1, 3'b001, 4'd0, 16'hEEEE);
        tick("rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("rst16.data", dout16, 16'h0000);
        chk("rst16.flags", {13'd0, carry16, busy16, done16}, 16'h0000);
        drv16(1'b0, 3'b000, 4'd0, 16'h0000);
        rst = 1'b0;

        drv8(1'b1, 3'b001, 3'd0, 8'hA5, 1'b0);
        tick("load_a5", 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0);
        drv8(1'b0, 3'b001, 3'd0, 8'h00, 1'b0);
        tick("hold", 1'b0, 16'h00A5, 1'b0, 1'b0, 1'b0);

        drv8(1'b1, 3'b001, 3'd0, 8'h96, 1'b0);
        tick("load_96", 1'b0, 16'h0096, 1'b0, 1'b0, 1'b0);
        drv8(1'b1, 3'b100, 3'd3, 8'h00, 1'b0);
        tick("sar3", 1'b0, 16'h00F2, 1'b1, 1'b0, 1'b0);
        drv8(1'b1, 3'b011, 3'd0, 8'h00, 1'b0);
        tick("shl0", 1'b0, 16'h00F2, 1'b1, 1'b0, 1'b0);

        drv8(1'b1, 3'b001, 3'd0, 8'h96, 1'b0);
        tick("load_96b", 1'b0, 16'h0096, 1'b0, 1'b0, 1'b0);
        drv8(1'b1, 3'b111, 3'd3, 8'h00, 1'b0);
        tick("rol3", 1'b0, 16'h00B4, 1'b0, 1'b0, 1'b0);
        drv8(1'b1, 3'b110, 3'd3, 8'h00, 1'b0);
        tick("ror3", 1'b0, 16'h0096, 1'b1, 1'b0, 1'b0);

        drv8(1'b1, 3'b101, 3'd0, 8'h00, bits[0]);
        tick("serin_start", 1'b0, 16'h0096, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 7; i++) begin
            drv8(1'b1, 3'b001, 3'd0, 8'hFF, bits[i]);
            tick($sformatf("serin_bit%0d", i), 1'b0, 16'h0096, 1'b1,
                 1'b1, 1'b0);
        end
        drv8(1'b1, 3'b001, 3'd0, 8'hFF, bits[7]);
        tick("serin_last", 1'b0, 16'h004D, 1'b1, 1'b0, 1'b1);
        drv8(1'b1, 3'b001, 3'd0, 8'h11, 1'b0);
        tick("load_in_done", 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0);

        drv8(1'b1, 3'b101, 3'd0, 8'h00, 1'b1);
        tick("abort_start", 1'b0, 16'h0011, 1'b0, 1'b1, 1'b0);
        drv8(1'b0, 3'b000, 3'd0, 8'h00, 1'b1);
        tick("abort_c1", 1'b0, 16'h0011, 1'b0, 1'b1, 1'b0);
        tick("abort_c2", 1'b0, 16'h0011, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick("abort_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick("abort_idle1", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        tick("abort_idle2", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        drv8(1'b1, 3'b001, 3'd0, 8'h3C, 1'b0);
        tick("load_3c", 1'b0, 16'h003C, 1'b0, 1'b0, 1'b0);

        md = 8'h3C;
        mc = 1'b0;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 5));
            if (o >= 3'd5) o = o + 3'd1;
            s = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            {mc, md} = mdl(o, s, d, md, mc);
            drv8(1'b1, o, s, d, 1'b0);
            tick($sformatf("rand%0d_op%0d_sh%0d", i, o, s), 1'b0,
                 {8'd0, md}, mc, 1'b0, 1'b0);
        end
        drv8(1'b0, 3'b000, 3'd0, 8'h00, 1'b0);

        drv16(1'b1, 3'b001, 4'd0, 16'h8000);
        tick("w16_load", 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b010, 4'd15, 16'h0000);
        tick("w16_shr15", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b011, 4'd15, 16'h0000);
        tick("w16_shl15", 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b001, 4'd0, 16'h8000);
        tick("w16_reload", 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b100, 4'd1, 16'h0000);
        tick("w16_sar1", 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b110, 4'd1, 16'h0000);
        tick("w16_ror1", 1'b1, 16'h6000, 1'b0, 1'b0, 1'b0);
        drv16(1'b1, 3'b111, 4'd2, 16'h0000);
        tick("w16_rol2", 1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);
        drv16(1'b0, 3'b000, 4'd0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_unit_param.md
Name: shift_unit_param

Overview:
- Parametrised successor to the 8-bit opcode-driven shift register.
- WIDTH-bit register with the same eight operations.
- New capabilities:
  - variable shift/rotate amount per operation;
  - carry-out of the last bit shifted out;
  - a proper multi-cycle serial-in collector with busy/done handshake.
- Sits between switch/key inputs or a host sequencer and LED/display logic.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount input.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation request; sampled only when busy=0
- op  in  3  opcode (see Behaviour)
- shamt  in  SHAMT_W  shift/rotate amount for SHR/SHL/SAR/ROR/ROL
- data_in  in  WIDTH  parallel load value
- ser_in  in  1  serial data for SERIN, LSB first
- data_out  out  WIDTH  register contents
- carry  out  1  last bit shifted or rotated out
- busy  out  1  high while SERIN collection is in progress
- done  out  1  one-cycle pulse after SERIN completes

Behaviour:
- Reset (rst=1 at a clk edge):
  - data_out=0, carry=0, busy=0, done=0;
  - state=IDLE, bit counter=0, shadow register=0.
  - Reset has priority over everything, including mid-collection. A partial SERIN is discarded and no done pulse is produced.
- Opcodes, applied at the clk edge where op_valid=1 and busy=0 (single-cycle latency):
  - 000 CLR: data_out=0, carry=0.
  - 001 LOAD: data_out=data_in, carry=0.
  - 010 SHR: logical right by shamt, zero fill; carry=data_out[shamt-1].
  - 011 SHL: left by shamt, zero fill; carry=data_out[WIDTH-shamt].
  - 100 SAR: arithmetic right by shamt, MSB fill; carry=data_out[shamt-1].
  - 101 SERIN: start collection (below).
  - 110 ROR: rotate right by shamt; carry=data_out[shamt-1].
  - 111 ROL: rotate left by shamt; carry=data_out[WIDTH-shamt].
- shamt rules:
  - shamt=0 for any shift/rotate: data_out and carry unchanged.
  - shamt >= WIDTH (non-power-of-2 WIDTH): SHR/SHL give 0, SAR gives all MSB, rotates use shamt mod WIDTH.
  - For out-of-range SHR/SHL/SAR, carry=0 (SHR/SHL) or the MSB (SAR).
- op_valid=0: register holds; carry holds.
- SERIN state machine, states IDLE and COLLECT:
  - IDLE, op_valid & op=101: sample ser_in into shadow[0], counter=1, go to COLLECT, busy=1 from the next cycle.
  - COLLECT: each edge samples ser_in into shadow[counter] and increments counter.
  - On the edge that samples bit WIDTH-1:
    - data_out={ser_in, shadow[WIDTH-2:0]};
    - carry unchanged;
    - state=IDLE, busy=0, done=1 for exactly the following cycle.
  - data_out is not altered during collection; intermediate bits are never visible.
  - busy is high for WIDTH-1 cycles. op_valid is ignored while busy (no queuing).
  - A new op may be accepted in the cycle where done=1.
  - Counter wraps to 0 on completion.

Decomposition:
- Package shift_unit_pkg holds:
  - opcode localparams OP_CLR..OP_ROL (3-bit);
  - state typedef {IDLE, COLLECT}.
- One sub-module, shift_barrel: combinational barrel shifter.
  - Inputs: value, shamt, op.
  - Outputs: shifted value and carry.
- Top module holds the registers, FSM, counter and shadow register.

Test Plan:
- WIDTH=8; reset, then LOAD data_in=0xA5 -> next cycle data_out=0xA5, carry=0, busy=0.
- LOAD 0x96, then SAR shamt=3 -> data_out=0xF2, carry=1. Then SHL shamt=0 -> data_out=0xF2, carry=1 unchanged.
- LOAD 0x96, then ROL shamt=3 -> data_out=0xB4, carry=0. Then ROR shamt=3 -> data_out=0x96, carry=1.
- SERIN with ser_in=1,0,1,1,0,0,1,0 on 8 consecutive edges; LOAD 0xFF requested during busy:
  - data_out stays at its old value until the 8th edge, then becomes 0x4D;
  - busy high 7 cycles, done pulses once;
  - the LOAD is ignored.
- Start SERIN, assert rst on the 4th collection edge -> data_out=0, busy=0, done never pulses; subsequent LOAD 0x3C accepted normally.
- WIDTH=16; LOAD 0x8000, SHR shamt=15 -> data_out=0x0001, carry=0. Then SAR shamt=1 on reloaded 0x8000 -> data_out=0xC000, carry=0.
